// File: rtl/ldpc_pkg.sv
// rtl/ldpc_pkg.sv - shared LDPC constants, encoder state encoding and clog2 helper
package ldpc_pkg;

    localparam int LDPC_N = 2304;
    localparam int LDPC_K = 1536;
    localparam int LDPC_W = 8;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DRAIN = 2'd1,
        ST_EMIT  = 2'd2
    } enc_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/ldpc_gen_rom.sv
// rtl/ldpc_gen_rom.sv - registered-read parity generator ROM, one word of W rows per info beat
module ldpc_gen_rom
    import ldpc_pkg::*;
#(
    parameter int                     DEPTH = 1,
    parameter int                     WIDTH = 8,
    parameter int                     AW    = (clog2(DEPTH) < 1) ? 1 : clog2(DEPTH),
    parameter logic [DEPTH*WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_addr,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] w_mem [2**AW];
    logic [WIDTH-1:0] r_data;

    // Word b of INIT sits at bits [b*WIDTH +: WIDTH]; unused power-of-two slots read as zero.
    for (genvar gi = 0; gi < 2**AW; gi++) begin : g_mem
        if (gi < DEPTH) begin : g_used
            assign w_mem[gi] = INIT[gi*WIDTH +: WIDTH];
        end else begin : g_pad
            assign w_mem[gi] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (i_rd_en) r_data <= w_mem[i_addr];
    end

    assign o_data = r_data;

endmodule

// File: rtl/ldpc_stream_encoder.sv
// rtl/ldpc_stream_encoder.sv - streaming systematic LDPC encoder; LDPC_ENC_SHORTEN_EN adds cfg_k_beats
module ldpc_stream_encoder
    import ldpc_pkg::*;
#(
    parameter int                       N              = LDPC_N,
    parameter int                       K              = LDPC_K,
    parameter int                       W              = LDPC_W,
    parameter int                       COUNT_MAX_BITS = 12,
    parameter logic [K*(N-K)-1:0]       GEN_INIT       = '0
) (
    input  logic                        clk,
    input  logic                        rst,
`ifdef LDPC_ENC_SHORTEN_EN
    input  logic [COUNT_MAX_BITS-1:0]   cfg_k_beats,
`endif
    input  logic [W-1:0]                in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [W-1:0]                out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy
);

    localparam int P      = N - K;
    localparam int KB     = K / W;
    localparam int PB     = P / W;
    localparam int ROM_AW = (clog2(KB) < 1) ? 1 : clog2(KB);
    localparam logic [COUNT_MAX_BITS-1:0] C_ONE     = COUNT_MAX_BITS'(1);
    localparam logic [COUNT_MAX_BITS-1:0] C_PB_LAST = COUNT_MAX_BITS'(PB - 1);

    enc_state_e                r_state;
    logic [COUNT_MAX_BITS-1:0] r_beat_cnt;
    logic [P-1:0]              r_acc;
    logic [W-1:0]              r_mac_dat;
    logic                      r_mac_vld;
    logic                      r_busy;

    logic [W*P-1:0]            w_rom_q;
    logic [P-1:0]              w_row_xor;
    logic [COUNT_MAX_BITS-1:0] w_k_last;
    logic                      w_in_hs;
    logic                      w_out_hs;

`ifdef LDPC_ENC_SHORTEN_EN
    logic [COUNT_MAX_BITS-1:0] r_k_last;
    logic [COUNT_MAX_BITS-1:0] w_cfg_eff;

    // Frame length is latched on the first beat; later beats use the latched value.
    assign w_cfg_eff = (cfg_k_beats == '0 || int'(cfg_k_beats) > KB) ? COUNT_MAX_BITS'(KB) : cfg_k_beats;
    assign w_k_last  = (r_beat_cnt == '0) ? (w_cfg_eff - C_ONE) : r_k_last;
`else
    assign w_k_last  = COUNT_MAX_BITS'(KB - 1);
`endif

    assign in_ready  = ~rst & (r_state == ST_ACCUM) & out_ready;
    assign out_valid = ~rst & ((r_state == ST_ACCUM) ? in_valid : (r_state == ST_EMIT));
    assign out_data  = (r_state == ST_EMIT) ? r_acc[int'(r_beat_cnt) * W +: W] : in_data;
    assign out_last  = ~rst & (r_state == ST_EMIT) & (r_beat_cnt == C_PB_LAST);
    assign busy      = r_busy;
    assign w_in_hs   = in_valid & in_ready;
    assign w_out_hs  = out_valid & out_ready;

    ldpc_gen_rom #(
        .DEPTH (KB),
        .WIDTH (W * P),
        .AW    (ROM_AW),
        .INIT  (GEN_INIT)
    ) u_gen_rom (
        .clk     (clk),
        .i_rd_en (w_in_hs),
        .i_addr  (r_beat_cnt[ROM_AW-1:0]),
        .o_data  (w_rom_q)
    );

    always_comb begin
        w_row_xor = '0;
        for (int i = 0; i < W; i++) begin
            if (r_mac_dat[i]) w_row_xor = w_row_xor ^ w_rom_q[i*P +: P];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_ACCUM;
            r_beat_cnt <= '0;
            r_acc      <= '0;
            r_mac_dat  <= '0;
            r_mac_vld  <= 1'b0;
            r_busy     <= 1'b0;
`ifdef LDPC_ENC_SHORTEN_EN
            r_k_last   <= '0;
`endif
        end else begin
            r_mac_vld <= 1'b0;
            if (r_mac_vld) r_acc <= r_acc ^ w_row_xor;
            case (r_state)
                ST_ACCUM: begin
                    if (w_in_hs) begin
                        r_mac_vld <= 1'b1;
                        r_mac_dat <= in_data;
                        r_busy    <= 1'b1;
`ifdef LDPC_ENC_SHORTEN_EN
                        if (r_beat_cnt == '0) r_k_last <= w_k_last;
`endif
                        if (r_beat_cnt == w_k_last) begin
                            r_beat_cnt <= '0;
                            r_state    <= ST_DRAIN;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + C_ONE;
                        end
                    end
                end
                ST_DRAIN: begin
                    r_state <= ST_EMIT;
                end
                ST_EMIT: begin
                    if (w_out_hs) begin
                        if (r_beat_cnt == C_PB_LAST) begin
                            r_acc      <= '0;
                            r_beat_cnt <= '0;
                            r_busy     <= 1'b0;
                            r_state    <= ST_ACCUM;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + C_ONE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ldpc_stream_encoder.sv
// tb/tb_ldpc_stream_encoder.sv - scoreboard bench for ldpc_stream_encoder (N=8, K=4, W=2)
module tb_ldpc_stream_encoder;

    localparam int N   = 8;
    localparam int K   = 4;
    localparam int W   = 2;
    localparam int CMB = 4;
    localparam int P   = N - K;
    localparam int KB  = K / W;
    localparam int PB  = P / W;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [W-1:0]   in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_last;
    logic           busy;
`ifdef LDPC_ENC_SHORTEN_EN
    logic [CMB-1:0] cfg_k_beats = '0;
`endif

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [P-1:0] g_rows [K] = '{4'h7, 4'hB, 4'hD, 4'hE};
    int           n_tests = 0;
    int           n_fail  = 0;
    int           bp_mode = 0;
    longint       cyc     = 0;

    ldpc_stream_encoder #(
        .N              (N),
        .K              (K),
        .W              (W),
        .COUNT_MAX_BITS (CMB),
        .GEN_INIT       (16'hEDB7)
    ) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef LDPC_ENC_SHORTEN_EN
        .cfg_k_beats (cfg_k_beats),
`endif
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic logic [P-1:0] ref_parity(input logic [K-1:0] u, input int nb);
        logic [P-1:0] p;
        p = '0;
        for (int r = 0; r < nb * W; r++) begin
            if (u[r]) p = p ^ g_rows[r];
        end
        return p;
    endfunction

    task automatic send_frame(input logic [K-1:0] u, input int nb, input bit lat_chk,
                              output longint first_cyc);
        logic [P-1:0] p;
        int           t;
        bit           done;
        first_cyc = 0;
        for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = u[b*W +: W];
            exp_q.push_back('{data: u[b*W +: W], last: 1'b0});
            t    = 0;
            done = 0;
            while (!done) begin
                #4;
                if (in_ready) begin
                    done = 1;
                end else begin
                    t++;
                    if (t > 200) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL in_handshake_timeout: got no in_ready expected handshake");
                        in_valid = 1'b0;
                        return;
                    end
                    @(negedge clk);
                end
            end
            if (b == 0) first_cyc = cyc;
        end
        p = ref_parity(u, nb);
        for (int j = 0; j < PB; j++) exp_q.push_back('{data: p[j*W +: W], last: (j == PB - 1)});
        if (lat_chk) begin
            @(negedge clk);
            in_data = W'($urandom);
            #4;
            chk("drain_out_valid", out_valid, 1'b0);
            chk("drain_in_ready", in_ready, 1'b0);
            @(negedge clk);
            in_data = W'($urandom);
            #4;
            chk("latency2_out_valid", out_valid, 1'b1);
            chk("emit_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else if (bp_mode == 0) out_ready = 1'b1;
        end
    end

    initial begin
        beat_t        e;
        logic         stalled;
        logic [W-1:0] sd;
        logic         sl;
        stalled = 0;
        sd      = '0;
        sl      = 0;
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                stalled = 0;
                continue;
            end
            if (stalled) begin
                chk("hold_valid", out_valid, 1'b1);
                chk("hold_data", out_data, sd);
                chk("hold_last", out_last, sl);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got data %0h last %0b expected no beat", out_data, out_last);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                end
                stalled = 0;
            end else begin
                stalled = out_valid;
                sd      = out_data;
                sl      = out_last;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        longint       f1, f2, fx;
        logic [K-1:0] u;
        logic [P-1:0] pe;
        int           t;

        in_valid = 1'b1;
        in_data  = 2'b11;
        repeat (3) begin
            @(negedge clk);
            #4;
            chk("rst_in_ready", in_ready, 1'b0);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_out_last", out_last, 1'b0);
            chk("rst_busy", busy, 1'b0);
        end
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        #4;
        chk("idle_in_ready", in_ready, 1'b1);
        chk("idle_out_valid", out_valid, 1'b0);

        send_frame(4'h0, KB, 0, fx);
        send_frame(4'h1, KB, 0, fx);
        send_frame(4'h3, KB, 0, fx);
        send_frame(4'hF, KB, 0, fx);

        // Hold parity while the sink stalls for three cycles.
        bp_mode = 2;
        out_ready = 1'b1;
        send_frame(4'h3, KB, 0, fx);
        pe = ref_parity(4'h3, KB);
        #4;
        repeat (3) begin
            @(negedge clk);
            out_ready = 1'b0;
            #4;
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, pe[W-1:0]);
            chk("stall_last", out_last, 1'b0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        bp_mode = 0;
        repeat (4) @(negedge clk);

        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 2'b11;
        exp_q.push_back('{data: 2'b11, last: 1'b0});
        #4;
        chk("abort_hs", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #4;
        chk("abort_busy_before", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        #4;
        chk("abort_rst_in_ready", in_ready, 1'b0);
        chk("abort_rst_out_valid", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        #4;
        chk("abort_busy_after", busy, 1'b0);
        chk("abort_out_valid", out_valid, 1'b0);
        send_frame(4'h1, KB, 0, fx);

        send_frame(4'h1, KB, 1, f1);
        send_frame(4'h2, KB, 0, f2);
        chk("frame_period", 32'(f2 - f1), KB + 1 + PB);

`ifdef LDPC_ENC_SHORTEN_EN
        cfg_k_beats = 4'd1;
        send_frame(4'h2, 1, 0, fx);
        cfg_k_beats = 4'd0;
        send_frame(4'h6, KB, 0, fx);
        cfg_k_beats = 4'd3;
        send_frame(4'h9, KB, 0, fx);
        cfg_k_beats = 4'd2;
`endif

        for (int i = 0; i < 24; i++) begin
            bp_mode = $urandom_range(0, 1);
            u = K'($urandom);
            send_frame(u, KB, 0, fx);
        end
        bp_mode = 0;

        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (2) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        chk("final_busy", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
